// File: rtl/bitrev_reorder_pp.sv
// Ping-pong frame buffer: writes N samples in natural order and reads them back
// bit-reversed (or natural when the frame was written with bypass=1).
module bitrev_reorder_pp #(
  parameter int DATA_W = 32,
  parameter int LOG2N  = 6
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              bypass,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              frame_err
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] mem_q [2*N];

  logic [1:0]       full_q, full_d;
  logic [1:0]       mode_q, mode_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
  logic             frame_err_q, frame_err_d;

  logic             wr_en, rd_en, wr_last, rd_last;
  logic [LOG2N-1:0] rd_addr;

  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign wr_en     = in_valid && in_ready;
  assign rd_en     = out_valid && out_ready;
  assign wr_last   = (wr_cnt_q == CNT_MAX);
  assign rd_last   = (rd_cnt_q == CNT_MAX);
  assign out_last  = out_valid && rd_last;
  assign frame_err = frame_err_q;

  always_comb begin
    rd_addr = rd_cnt_q;
    if (!mode_q[rd_bank_q]) begin
      for (int i = 0; i < LOG2N; i++) begin
        rd_addr[i] = rd_cnt_q[LOG2N-1-i];
      end
    end
  end

  assign out_data = mem_q[{rd_bank_q, rd_addr}];

  // Write and read completions never hit the same bank, so both full updates can apply.
  always_comb begin
    full_d      = full_q;
    mode_d      = mode_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    frame_err_d = frame_err_q;
    if (wr_en) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_cnt_q == '0) begin
        mode_d[wr_bank_q] = bypass;
      end
      if (wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
      if (in_last != wr_last) begin
        frame_err_d = 1'b1;
      end
    end
    if (rd_en) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
      if (rd_last) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      full_q      <= '0;
      mode_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      full_q      <= full_d;
      mode_q      <= mode_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[{wr_bank_q, wr_cnt_q}] <= in_data;
    end
  end

endmodule

// File: tb/tb_bitrev_reorder_pp.sv
// Directed bench for bitrev_reorder_pp: an 8-sample instance for the corner
// cases and a 64-sample instance for sustained back-to-back streaming.
module tb_bitrev_reorder_pp;

  typedef struct {
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        bypass;
    logic        out_ready;
    logic        exp_ready;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_last;
    logic        exp_err;
  } vec_t;

  logic clk;
  logic nrst;

  logic        i3_valid, i3_last, i3_bypass, o3_ready;
  logic [31:0] i3_data;
  logic        in_ready3, out_valid3, out_last3, frame_err3;
  logic [31:0] out_data3;

  logic        i6_valid, i6_last, i6_bypass, o6_ready;
  logic [31:0] i6_data;
  logic        in_ready6, out_valid6, out_last6, frame_err6;
  logic [31:0] out_data6;

  int n_cmp = 0;
  int n_err = 0;
  int rev3 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  vec_t vecs [$];

  bitrev_reorder_pp #(.DATA_W(32), .LOG2N(3)) dut3 (
    .clk(clk), .nrst(nrst),
    .in_valid(i3_valid), .in_ready(in_ready3), .in_data(i3_data), .in_last(i3_last),
    .bypass(i3_bypass),
    .out_valid(out_valid3), .out_ready(o3_ready), .out_data(out_data3), .out_last(out_last3),
    .frame_err(frame_err3)
  );

  bitrev_reorder_pp #(.DATA_W(32), .LOG2N(6)) dut6 (
    .clk(clk), .nrst(nrst),
    .in_valid(i6_valid), .in_ready(in_ready6), .in_data(i6_data), .in_last(i6_last),
    .bypass(i6_bypass),
    .out_valid(out_valid6), .out_ready(o6_ready), .out_data(out_data6), .out_last(out_last6),
    .frame_err(frame_err6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rev6(int i);
    logic [5:0] b;
    b = 6'(i);
    return int'({b[0], b[1], b[2], b[3], b[4], b[5]});
  endfunction

  function automatic vec_t mk(bit iv, int d, bit il, bit bp, bit ordy,
                              bit er, bit ev, int ed, bit el, bit ee);
    vec_t v;
    v.in_valid  = iv;
    v.in_data   = 32'(d);
    v.in_last   = il;
    v.bypass    = bp;
    v.out_ready = ordy;
    v.exp_ready = er;
    v.exp_valid = ev;
    v.exp_data  = 32'(ed);
    v.exp_last  = el;
    v.exp_err   = ee;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Compares every output of the 8-sample instance; data only matters while valid.
  task automatic check3(input string tag, input bit er, input bit ev, input int ed,
                        input bit el, input bit ee);
    checkOutput({tag, " in_ready"}, 32'(in_ready3), 32'(er));
    checkOutput({tag, " out_valid"}, 32'(out_valid3), 32'(ev));
    checkOutput({tag, " out_last"}, 32'(out_last3), 32'(el));
    checkOutput({tag, " frame_err"}, 32'(frame_err3), 32'(ee));
    if (ev) checkOutput({tag, " out_data"}, out_data3, 32'(ed));
  endtask

  task automatic applyStimulus(input vec_t v);
    i3_valid  = v.in_valid;
    i3_data   = v.in_data;
    i3_last   = v.in_last;
    i3_bypass = v.bypass;
    o3_ready  = v.out_ready;
  endtask

  initial begin
    nrst = 1'b0;
    i3_valid = 1'b0; i3_data = '0; i3_last = 1'b0; i3_bypass = 1'b0; o3_ready = 1'b0;
    i6_valid = 1'b0; i6_data = '0; i6_last = 1'b0; i6_bypass = 1'b0; o6_ready = 1'b0;
    step();
    step();
    nrst = 1'b1;

    check3("reset", 1'b1, 1'b0, 0, 1'b0, 1'b0);
    checkOutput("reset6 in_ready", 32'(in_ready6), 32'd1);
    checkOutput("reset6 out_valid", 32'(out_valid6), 32'd0);

    // Basic reorder: words 0..7, then drained as 0,4,2,6,1,5,3,7
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(1'b1, k, k == 7, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0));
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, rev3[k], k == 7, 1'b0));
    vecs.push_back(mk(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0));
    // Bypass frame then reordered frame, with bypass toggling mid-frame
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(1'b1, 100 + k, k == 7, (k == 0) ? 1'b1 : k[0], 1'b1,
                        1'b1, 1'b0, 0, 1'b0, 1'b0));
    for (int j = 0; j < 8; j++)
      vecs.push_back(mk(1'b1, 108 + j, j == 7, (j == 0) ? 1'b0 : j[0], 1'b1,
                        1'b1, 1'b1, 100 + j, j == 7, 1'b0));
    for (int j = 0; j < 8; j++)
      vecs.push_back(mk(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 108 + rev3[j], j == 7, 1'b0));
    vecs.push_back(mk(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      check3($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_valid,
             int'(vecs[i].exp_data), vecs[i].exp_last, vecs[i].exp_err);
      applyStimulus(vecs[i]);
      step();
    end
    i3_valid = 1'b0; i3_bypass = 1'b0;

    // Stall: fill both banks with out_ready low
    o3_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("stall w%0d in_ready", k), 32'(in_ready3), 32'd1);
      if (k >= 8) begin
        checkOutput($sformatf("stall w%0d out_valid", k), 32'(out_valid3), 32'd1);
        checkOutput($sformatf("stall w%0d out_data", k), out_data3, 32'd0);
      end
      i3_valid = 1'b1; i3_data = 32'(k); i3_last = (k % 8 == 7);
      step();
    end
    for (int k = 0; k < 2; k++) begin
      i3_valid = 1'b1; i3_data = 32'd99; i3_last = 1'b0;
      check3($sformatf("stall hold%0d", k), 1'b0, 1'b1, 0, 1'b0, 1'b0);
      step();
    end
    i3_valid = 1'b0; i3_last = 1'b0;
    o3_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check3($sformatf("stall rd0_%0d", i), 1'b0, 1'b1, rev3[i], i == 7, 1'b0);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      check3($sformatf("stall rd1_%0d", i), 1'b1, 1'b1, 8 + rev3[i], i == 7, 1'b0);
      step();
    end
    check3("stall drained", 1'b1, 1'b0, 0, 1'b0, 1'b0);

    // Early in_last on word 5: error is sticky, frame length unchanged
    for (int k = 0; k < 8; k++) begin
      check3($sformatf("ferr w%0d", k), 1'b1, 1'b0, 0, 1'b0, k > 5);
      i3_valid = 1'b1; i3_data = 32'(200 + k); i3_last = (k == 5);
      step();
    end
    i3_valid = 1'b0; i3_last = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check3($sformatf("ferr rd%0d", i), 1'b1, 1'b1, 200 + rev3[i], i == 7, 1'b1);
      step();
    end
    check3("ferr drained", 1'b1, 1'b0, 0, 1'b0, 1'b1);

    // Reset after a partial frame
    for (int k = 0; k < 5; k++) begin
      i3_valid = 1'b1; i3_data = 32'(50 + k); i3_last = 1'b0;
      step();
    end
    i3_valid = 1'b0;
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check3($sformatf("rst idle%0d", k), 1'b1, 1'b0, 0, 1'b0, 1'b0);
      step();
    end
    for (int k = 0; k < 8; k++) begin
      check3($sformatf("rst w%0d", k), 1'b1, 1'b0, 0, 1'b0, 1'b0);
      i3_valid = 1'b1; i3_data = 32'(300 + k); i3_last = (k == 7);
      step();
    end
    i3_valid = 1'b0; i3_last = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check3($sformatf("rst rd%0d", i), 1'b1, 1'b1, 300 + rev3[i], i == 7, 1'b0);
      step();
    end
    check3("rst drained", 1'b1, 1'b0, 0, 1'b0, 1'b0);

    // Four back-to-back 64-sample frames at full rate
    o6_ready = 1'b1;
    for (int c = 0; c < 320; c++) begin
      if (c < 256)
        checkOutput($sformatf("b2b c%0d in_ready", c), 32'(in_ready6), 32'd1);
      if (c >= 64) begin
        checkOutput($sformatf("b2b c%0d out_valid", c), 32'(out_valid6), 32'd1);
        checkOutput($sformatf("b2b c%0d out_data", c), out_data6,
                    32'(64 * ((c - 64) / 64) + rev6((c - 64) % 64)));
        checkOutput($sformatf("b2b c%0d out_last", c), 32'(out_last6),
                    32'(((c - 64) % 64) == 63));
      end
      i6_valid = (c < 256);
      i6_data  = 32'(c);
      i6_last  = (c % 64 == 63);
      step();
    end
    i6_valid = 1'b0; i6_last = 1'b0;
    checkOutput("b2b end out_valid", 32'(out_valid6), 32'd0);
    checkOutput("b2b end frame_err", 32'(frame_err6), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
